lenet_argmax_reader: RTL and testbench

Result-side reader for the LeNet accelerator. On a start pulse it sequentially reads the NUM_CLASSES final-layer class scores from the accelerator's output score bank (synchronous read, 1-cycle latency). It finds the signed maximum and reports the winning class index with a one-cycle done pulse. It sits between LeNet_TOP's fc-output storage and the system/bench that consumes the classification.

---
 rtl/lenet_argmax_reader_if.sv | 36 +++
 rtl/lenet_argmax_reader.sv | 140 ++++++++++++++
 tb/tb_lenet_argmax_reader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_argmax_reader_if.sv
// Score-bank read bus plus start/result handshake for lenet_argmax_reader.
// Optional: LENET_ARGMAX_CYCCNT_EN adds the cyc_cnt result field.
interface lenet_argmax_reader_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] class_id;
  logic [DATA_W-1:0] max_score;
`ifdef LENET_ARGMAX_CYCCNT_EN
  logic [15:0]       cyc_cnt;
`endif

  // Reader side: issues bank reads, reports the classification.
  modport master (
    input  start, rd_data,
    output rd_en, rd_addr, busy, done, class_id, max_score
`ifdef LENET_ARGMAX_CYCCNT_EN
    , output cyc_cnt
`endif
  );

  // Bank / consumer side.
  modport slave (
    output start, rd_data,
    input  rd_en, rd_addr, busy, done, class_id, max_score
`ifdef LENET_ARGMAX_CYCCNT_EN
    , input cyc_cnt
`endif
  );
endinterface

// File: rtl/lenet_argmax_reader.sv
// Reads NUM_CLASSES signed scores from a 1-cycle-latency bank and reports
// the index/value of the maximum (ties keep the lowest index).
// Optional: LENET_ARGMAX_CYCCNT_EN adds a busy-cycle counter latched at done.
module lenet_argmax_reader #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  lenet_argmax_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vld_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] class_id_q, class_id_d;
  logic [DATA_W-1:0] max_q, max_d;

  // Next-state and read-strobe generation.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
        end
      end
      S_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Running signed maximum; the first sample of a run always loads.
  always_comb begin
    class_id_d = class_id_q;
    max_d      = max_q;
    if (vld_q) begin
      if ((idx_q == '0) || ($signed(bus.rd_data) > $signed(max_q))) begin
        class_id_d = idx_q;
        max_d      = bus.rd_data;
      end
    end
  end

  // State, strobe, compare-pipeline and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      class_id_q <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_q      <= rd_en_q;
      idx_q      <= rd_addr_q;
      class_id_q <= class_id_d;
      max_q      <= max_d;
    end
  end

  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.class_id  = class_id_q;
  assign bus.max_score = max_q;

`ifdef LENET_ARGMAX_CYCCNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  // Saturating busy-cycle counter, snapshot taken on entry to DONE.
  always_comb begin
    cnt_d     = cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    if ((state_q == S_IDLE) && bus.start) begin
      cnt_d = '0;
    end else if (busy_q && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (state_d == S_DONE) begin
      cyc_cnt_d = cnt_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cyc_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign bus.cyc_cnt = cyc_cnt_q;
`endif
endmodule

// File: tb/tb_lenet_argmax_reader.sv
// Directed bench for lenet_argmax_reader: vector table plus timing corner cases.
module tb_lenet_argmax_reader;
  localparam int unsigned N  = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lenet_argmax_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lenet_argmax_reader #(
    .NUM_CLASSES(N),
    .DATA_W     (DW),
    .ADDR_W     (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Score bank model: synchronous read, one cycle latency.
  logic [DW-1:0] bank [16];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= bank[bus.rd_addr];

  // Cycle index: value seen at a negedge names the cycle following the last edge.
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;
  function automatic int cur();
    return ecnt + 1;
  endfunction

  // Done logger: time and result captured in the done cycle.
  int            done_cyc [$];
  logic [AW-1:0] done_id  [$];
  logic [DW-1:0] done_mx  [$];
  logic [15:0]   done_cc  [$];
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cyc.push_back(cur());
      done_id.push_back(bus.class_id);
      done_mx.push_back(bus.max_score);
`ifdef LENET_ARGMAX_CYCCNT_EN
      done_cc.push_back(bus.cyc_cnt);
`else
      done_cc.push_back(16'd0);
`endif
    end
  end

  task automatic clear_log();
    done_cyc.delete(); done_id.delete(); done_mx.delete(); done_cc.delete();
  endtask

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0][DW-1:0] s;
    logic [AW-1:0]        id;
    logic [DW-1:0]        mx;
  } vec_t;
  vec_t vecs [7];

  task automatic load(input int vi);
    for (int i = 0; i < 16; i++) bank[i] = '0;
    for (int i = 0; i < int'(N); i++) bank[i] = vecs[vi].s[i];
  endtask

  // One start pulse; checks the read sequence, done timing and result.
  task automatic run_vec(input int vi);
    int k;
    logic seq_ok;
    load(vi);
    clear_log();
    seq_ok = 1'b1;
    @(negedge clk);
    k = cur();
    bus.start = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (j <= 10) begin
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== AW'(j - 1) || bus.busy !== 1'b1) seq_ok = 1'b0;
      end else if (j == 11) begin
        if (bus.rd_en !== 1'b0 || bus.rd_addr !== AW'(N - 1) || bus.busy !== 1'b1) seq_ok = 1'b0;
      end else if (j == 12) begin
        if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) seq_ok = 1'b0;
      end
    end
    chk($sformatf("v%0d_seq", vi), 32'(seq_ok), 32'd1);
    chk($sformatf("v%0d_ndone", vi), 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() >= 1) begin
      chk($sformatf("v%0d_done_cyc", vi), 32'(done_cyc[0] - k), 32'd12);
      chk($sformatf("v%0d_class_id", vi), 32'(done_id[0]), 32'(vecs[vi].id));
      chk($sformatf("v%0d_max_score", vi), 32'(done_mx[0]), 32'(vecs[vi].mx));
`ifdef LENET_ARGMAX_CYCCNT_EN
      chk($sformatf("v%0d_cyc_cnt", vi), 32'(done_cc[0]), 32'd11);
`endif
    end
  endtask

  int neg_vals [N] = '{-10, -3, -7, -3, -100, -50, -4, -9, -8, -20};

  initial begin
    int k;
    logic quiet;
    bus.start = 1'b0;
    bus.rd_data = '0;
    for (int i = 0; i < 16; i++) bank[i] = '0;

    // Vector table.
    vecs[0].s = {16'd8, 16'd4, 16'd99, 16'hFFFF, 16'd0, 16'd2, 16'd100, 16'd7, 16'hFFFB, 16'd3};
    vecs[0].id = 4'd3; vecs[0].mx = 16'd100;
    for (int i = 0; i < int'(N); i++) vecs[1].s[i] = 16'h8000;
    vecs[1].s[6] = 16'hFFFE; vecs[1].s[8] = 16'hFFFE;
    vecs[1].id = 4'd6; vecs[1].mx = 16'hFFFE;
    for (int i = 0; i < int'(N); i++) vecs[2].s[i] = 16'd5;
    vecs[2].id = 4'd0; vecs[2].mx = 16'd5;
    for (int i = 0; i < int'(N); i++) vecs[3].s[i] = 16'd1;
    vecs[3].s[9] = 16'd2;
    vecs[3].id = 4'd9; vecs[3].mx = 16'd2;
    for (int i = 0; i < int'(N); i++) vecs[4].s[i] = 16'h8000;
    vecs[4].id = 4'd0; vecs[4].mx = 16'h8000;
    for (int i = 0; i < int'(N); i++) vecs[5].s[i] = 16'h8000;
    vecs[5].s[5] = 16'h7FFF;
    vecs[5].id = 4'd5; vecs[5].mx = 16'h7FFF;
    for (int i = 0; i < int'(N); i++) vecs[6].s[i] = DW'(neg_vals[i]);
    vecs[6].id = 4'd1; vecs[6].mx = 16'hFFFD;

    // Reset values.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_class_id", 32'(bus.class_id), 32'd0);
    chk("rst_max_score", 32'(bus.max_score), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
    end
    chk("idle_quiet", 32'(quiet), 32'd1);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Second start while busy is ignored.
    load(0);
    clear_log();
    @(negedge clk);
    k = cur();
    bus.start = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      bus.start = (j == 4);
    end
    chk("busy_start_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() >= 1) chk("busy_start_cyc", 32'(done_cyc[0] - k), 32'd12);

    // Continuous start: back-to-back runs with a one-cycle IDLE gap.
    load(2);
    clear_log();
    @(negedge clk);
    k = cur();
    bus.start = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (done_cyc.size() == 3) break;
    end
    bus.start = 1'b0;
    chk("cont_ndone", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      chk("cont_done0", 32'(done_cyc[0] - k), 32'd12);
      chk("cont_done1", 32'(done_cyc[1] - k), 32'd25);
      chk("cont_done2", 32'(done_cyc[2] - k), 32'd38);
      chk("cont_id2", 32'(done_id[2]), 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("cont_idle", 32'(bus.busy), 32'd0);

    // Reset mid-run aborts; a fresh start afterwards completes normally.
    load(0);
    clear_log();
    @(negedge clk);
    k = cur();
    bus.start = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrst_pre_rd_en", 32'(bus.rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_max", 32'(bus.max_score), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_cyc", 32'(cur() - k), 32'd10);
    bus.start = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("midrst_ndone", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() >= 1) begin
      chk("midrst_done_cyc", 32'(done_cyc[0] - k), 32'd22);
      chk("midrst_id", 32'(done_id[0]), 32'd3);
      chk("midrst_mx", 32'(done_mx[0]), 32'd100);
    end
    chk("end_class_hold", 32'(bus.class_id), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
